// File: rtl/fpu_pkg.sv
// Shared FPU definitions: arbiter FSM state encoding and the f2i invalid-result value.
package fpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [31:0] F2I_INVALID_VAL = 32'h8000_0000;

endpackage

// File: rtl/f2i.sv
// Combinational IEEE-754 single to int32 conversion, truncating toward zero.
module f2i
    import fpu_pkg::*;
(
    input  logic [31:0] a,
    output logic [31:0] d,
    output logic        p_lost,
    output logic        denorm,
    output logic        invalid
);

    logic        sign;
    logic [7:0]  exp_f;
    logic [22:0] frac;
    logic        hidden;
    logic [4:0]  shamt;
    logic [55:0] shifted;
    logic [31:0] mag;

    assign sign   = a[31];
    assign exp_f  = a[30:23];
    assign frac   = a[22:0];
    assign hidden = |exp_f;
    assign denorm = ~hidden & (|frac);
    // 158 - exp mod 32; exact for the only exponents that use it (127..157)
    assign shamt  = 5'd30 - exp_f[4:0];

    always_comb begin
        shifted = {hidden, frac, 32'h0} >> shamt;
        mag     = shifted[55:24];
        d       = '0;
        p_lost  = 1'b0;
        invalid = 1'b0;
        if (exp_f == 8'hFF) begin
            invalid = 1'b1;
            d       = F2I_INVALID_VAL;
        end else if (exp_f < 8'd127) begin
            p_lost = hidden | (|frac);
        end else if (exp_f >= 8'd158) begin
            // only -2^31 exactly is representable; its bit pattern equals the invalid value
            invalid = ~(sign && (exp_f == 8'd158) && (frac == '0));
            d       = F2I_INVALID_VAL;
        end else begin
            d      = sign ? -mag : mag;
            p_lost = |shifted[23:0];
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: priority starts at ptr and ascends modulo N_REQ.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    input  logic             en,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  id
);

    localparam logic [ID_W:0] N_L = (ID_W+1)'(N_REQ);

    logic [ID_W:0] pos;
    logic          found;

    always_comb begin
        gnt   = '0;
        id    = '0;
        found = 1'b0;
        pos   = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            pos = {1'b0, ptr} + (ID_W+1)'(k);
            if (pos >= N_L) pos = pos - N_L;
            if (en && !found && req[pos[ID_W-1:0]]) begin
                gnt[pos[ID_W-1:0]] = 1'b1;
                id                 = pos[ID_W-1:0];
                found              = 1'b1;
            end
        end
    end

endmodule

// File: rtl/f2i_arbiter.sv
// Shares one f2i converter among N_REQ requesters with round-robin arbitration,
// registered operand/result and an invalid-result counter.
module f2i_arbiter
    import fpu_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                clrn,
    input  logic [N_REQ-1:0]    req_valid,
    input  logic [N_REQ*32-1:0] req_a,
    output logic [N_REQ-1:0]    req_ready,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [ID_W-1:0]     rsp_id,
    output logic [31:0]         rsp_d,
    output logic                rsp_p_lost,
    output logic                rsp_denorm,
    output logic                rsp_invalid,
    output logic [CNT_W-1:0]    inv_count,
    input  logic                cnt_clr
);

    localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_REQ - 1);

    state_t           state, state_nx;
    logic [ID_W-1:0]  ptr;
    logic [ID_W-1:0]  op_id;
    logic [31:0]      op_a;
    logic [N_REQ-1:0] gnt;
    logic [ID_W-1:0]  gnt_id;
    logic             arb_en;
    logic             granted;
    logic [31:0]      f_d;
    logic             f_p_lost, f_denorm, f_invalid;

    // clrn gating keeps req_ready low while reset is asserted
    assign arb_en    = clrn & ((state == IDLE) | ((state == RESP) & rsp_ready));
    assign granted   = |gnt;
    assign req_ready = gnt;

    rr_arbiter #(
        .N_REQ(N_REQ),
        .ID_W (ID_W)
    ) u_arb (
        .req(req_valid),
        .ptr(ptr),
        .en (arb_en),
        .gnt(gnt),
        .id (gnt_id)
    );

    f2i u_f2i (
        .a      (op_a),
        .d      (f_d),
        .p_lost (f_p_lost),
        .denorm (f_denorm),
        .invalid(f_invalid)
    );

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (granted) state_nx = CONV;
            CONV:    state_nx = RESP;
            RESP:    if (rsp_ready) state_nx = granted ? CONV : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state <= IDLE;
            ptr   <= '0;
            op_a  <= '0;
            op_id <= '0;
        end else begin
            state <= state_nx;
            if (granted) begin
                op_a  <= req_a[32*gnt_id +: 32];
                op_id <= gnt_id;
                ptr   <= (gnt_id == LAST_ID) ? '0 : gnt_id + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            rsp_valid   <= 1'b0;
            rsp_id      <= '0;
            rsp_d       <= '0;
            rsp_p_lost  <= 1'b0;
            rsp_denorm  <= 1'b0;
            rsp_invalid <= 1'b0;
        end else if (state == CONV) begin
            rsp_valid   <= 1'b1;
            rsp_id      <= op_id;
            rsp_d       <= f_d;
            rsp_p_lost  <= f_p_lost;
            rsp_denorm  <= f_denorm;
            rsp_invalid <= f_invalid;
        end else if ((state == RESP) && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            inv_count <= '0;
        end else if (cnt_clr) begin
            inv_count <= '0;
        end else if ((state == CONV) && f_invalid && (inv_count != '1)) begin
            inv_count <= inv_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_f2i_arbiter.sv
// Directed and randomized bench for f2i_arbiter against a transaction-level reference model.
module tb_f2i_arbiter;

    localparam int N  = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          clrn;
    logic [N-1:0]  req_valid;
    logic [N*32-1:0] req_a;
    logic [N-1:0]  req_ready;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [1:0]    rsp_id;
    logic [31:0]   rsp_d;
    logic          rsp_p_lost, rsp_denorm, rsp_invalid;
    logic [CW-1:0] inv_count;
    logic          cnt_clr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    f2i_arbiter #(
        .N_REQ(N),
        .ID_W (2),
        .CNT_W(CW)
    ) dut (
        .clk        (clk),
        .clrn       (clrn),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_d      (rsp_d),
        .rsp_p_lost (rsp_p_lost),
        .rsp_denorm (rsp_denorm),
        .rsp_invalid(rsp_invalid),
        .inv_count  (inv_count),
        .cnt_clr    (cnt_clr)
    );

    // Reference model: one outstanding transaction, visible one edge after acceptance.
    int          m_ptr;
    bit          m_have, m_shown;
    int          m_cnt;
    logic [1:0]  e_id;
    logic [31:0] e_d;
    logic        e_pl, e_dn, e_inv;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Value = m * 2^s; truncate toward zero, then range-check against int32.
    function automatic void ref_f2i(input logic [31:0] a, output logic [31:0] d,
                                    output logic pl, output logic dn, output logic inv);
        int     e;
        int     s;
        longint m;
        longint mag;
        e   = int'(a[30:23]);
        m   = longint'({1'b1, a[22:0]});
        mag = 0;
        dn  = (e == 0) && (a[22:0] != 0);
        inv = 1'b0;
        pl  = 1'b0;
        d   = '0;
        if (e == 255) begin
            inv = 1'b1;
        end else if (e == 0) begin
            pl = dn;
        end else begin
            s = e - 150;
            if (s > 8) begin
                inv = 1'b1;
            end else if (s >= 0) begin
                mag = m << s;
            end else begin
                mag = m >> (-s);
                pl  = ((mag << (-s)) != m);
            end
            if (!inv) begin
                if (a[31]) begin
                    if (mag > 64'd2147483648) inv = 1'b1;
                    else d = 32'(-mag);
                end else begin
                    if (mag > 64'd2147483647) inv = 1'b1;
                    else d = 32'(mag);
                end
            end
        end
        if (inv) begin
            d  = 32'h8000_0000;
            pl = 1'b0;
        end
    endfunction

    function automatic logic [31:0] rnd_op();
        logic [31:0] v;
        v = $urandom;
        case ($urandom_range(0, 5))
            0, 1, 2: v[30:23] = 8'($urandom_range(120, 160));
            3:       v[30:23] = 8'h00;
            4:       v[30:23] = 8'hFF;
            default: ;
        endcase
        return v;
    endfunction

    task automatic set_a(input int i, input logic [31:0] v);
        req_a[i*32 +: 32] = v;
    endtask

    task automatic model_reset();
        m_ptr   = 0;
        m_have  = 0;
        m_shown = 0;
        m_cnt   = 0;
    endtask

    // Checks one cycle at the falling edge, advances the model, returns 1 after the rising edge.
    task automatic tick();
        int           win;
        int           idx;
        logic [N-1:0] eg;
        bit           consumed;
        @(negedge clk);
        win = -1;
        eg  = '0;
        if (!m_have || (m_shown && rsp_ready)) begin
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (win < 0 && req_valid[idx]) win = idx;
            end
        end
        if (win >= 0) eg[win] = 1'b1;
        chk("req_ready", req_ready, eg);
        chk("rsp_valid", rsp_valid, m_shown);
        if (m_shown) begin
            chk("rsp_id", rsp_id, e_id);
            chk("rsp_d", rsp_d, e_d);
            chk("rsp_p_lost", rsp_p_lost, e_pl);
            chk("rsp_denorm", rsp_denorm, e_dn);
            chk("rsp_invalid", rsp_invalid, e_inv);
        end
        chk("inv_count", inv_count, m_cnt);

        consumed = m_shown && rsp_ready;
        if (cnt_clr) m_cnt = 0;
        else if (m_have && !m_shown && e_inv && m_cnt < (2**CW - 1)) m_cnt++;
        if (m_have && !m_shown) m_shown = 1;
        else if (consumed) begin
            m_have  = 0;
            m_shown = 0;
        end
        if (win >= 0) begin
            m_have  = 1;
            m_shown = 0;
            e_id    = 2'(win);
            ref_f2i(req_a[win*32 +: 32], e_d, e_pl, e_dn, e_inv);
            m_ptr   = (win + 1) % N;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        clrn      = 1'b0;
        req_valid = '1;
        req_a     = '0;
        rsp_ready = 1'b0;
        cnt_clr   = 1'b0;
        model_reset();
        #2;
        chk("reset_req_ready", req_ready, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_d", rsp_d, 0);
        chk("reset_rsp_id", rsp_id, 0);
        chk("reset_inv_count", inv_count, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        req_valid = '0;
        clrn = 1'b1;
        tick();

        // 1: 1.5 from requester 0
        set_a(0, 32'h3FC0_0000); req_valid = 4'b0001; rsp_ready = 1'b1;
        tick();
        req_valid = '0;
        tick();
        chk("t1_rsp_valid", rsp_valid, 1);
        chk("t1_rsp_d", rsp_d, 32'd1);
        chk("t1_p_lost", rsp_p_lost, 1);
        chk("t1_rsp_id", rsp_id, 0);
        tick();

        // 2: 2^31 is out of range, then -1.0
        set_a(2, 32'h4F00_0000); req_valid = 4'b0100;
        tick();
        req_valid = '0;
        tick();
        chk("t2_invalid", rsp_invalid, 1);
        chk("t2_rsp_d", rsp_d, 32'h8000_0000);
        tick();
        chk("t2_inv_count", inv_count, 1);
        set_a(2, 32'hBF80_0000); req_valid = 4'b0100;
        tick();
        req_valid = '0;
        tick();
        chk("t2_neg_d", rsp_d, 32'hFFFF_FFFF);
        chk("t2_neg_p_lost", rsp_p_lost, 0);
        tick();

        // 3: all requesters held valid, back-to-back
        set_a(0, 32'h4040_0000); set_a(1, 32'hC0A0_0000);
        set_a(2, 32'h4B00_0001); set_a(3, 32'h3F00_0000);
        req_valid = 4'b1111;
        for (int c = 0; c < 12; c++) tick();
        req_valid = '0;
        tick(); tick();

        // 4: backpressure with requester 1 waiting
        set_a(0, 32'h4120_0000); req_valid = 4'b0001; rsp_ready = 1'b0;
        tick();
        req_valid = 4'b0010; set_a(1, 32'hC2F6_0000);
        tick();
        for (int c = 0; c < 5; c++) tick();
        chk("t4_held_d", rsp_d, 32'd10);
        rsp_ready = 1'b1;
        tick();
        req_valid = '0;
        tick(); tick();

        // 5: smallest denormal, then quiet NaN
        set_a(3, 32'h0000_0001); req_valid = 4'b1000;
        tick();
        req_valid = '0;
        tick();
        chk("t5_denorm", rsp_denorm, 1);
        chk("t5_denorm_d", rsp_d, 0);
        tick();
        set_a(3, 32'h7FC0_0000); req_valid = 4'b1000;
        tick();
        req_valid = '0;
        tick();
        chk("t5_nan_invalid", rsp_invalid, 1);
        tick();

        // 6a: clear coinciding with an invalid result
        set_a(0, 32'h7F80_0000); req_valid = 4'b0001;
        tick();
        req_valid = '0; cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("t6_clr_wins", inv_count, 0);
        tick();

        // 6b: reset while converting; ptr was moved off zero
        set_a(2, 32'h7F80_0000); req_valid = 4'b0100;
        tick();
        req_valid = '0;
        clrn = 1'b0;
        #1;
        chk("t6_rst_rsp_valid", rsp_valid, 0);
        chk("t6_rst_req_ready", req_ready, 0);
        chk("t6_rst_inv_count", inv_count, 0);
        model_reset();
        @(posedge clk); #1;
        clrn = 1'b1;
        tick(); tick();
        for (int i = 0; i < N; i++) set_a(i, 32'h4200_0000 + 32'(i << 20));
        req_valid = 4'b1111;
        for (int c = 0; c < 9; c++) tick();
        req_valid = '0;
        tick(); tick();

        // counter saturation
        set_a(1, 32'hFF80_0000); req_valid = 4'b0010;
        for (int c = 0; c < 40; c++) tick();
        req_valid = '0;
        tick(); tick();
        chk("sat_inv_count", inv_count, 4'hF);

        // randomized traffic
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++) set_a(i, rnd_op());
            req_valid = 4'($urandom);
            rsp_ready = ($urandom_range(0, 9) < 7);
            cnt_clr   = ($urandom_range(0, 39) == 0);
            tick();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        cnt_clr   = 1'b0;
        tick(); tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
